// File: rtl/acpram_axi_cmd_queue_if.sv
// rtl/acpram_axi_cmd_queue_if.sv - command/response link between the queue and the ACP-RAM<->AXI engine
`timescale 1ns/1ps
interface acpram_axi_interface #(
  parameter int ACPRAM_ADDR_WIDTH = 12,
  parameter int AXI_ADDR_WIDTH    = 32
);
  logic                         read;
  logic                         write;
  logic [ACPRAM_ADDR_WIDTH-1:0] acpram_addr;
  logic [AXI_ADDR_WIDTH-1:0]    axi_addr;
  logic                         len;
  logic                         done;
  logic                         error;
  logic                         busy;

  modport master (
    output read, write, acpram_addr, axi_addr, len,
    input  done, error, busy
  );

  modport slave (
    input  read, write, acpram_addr, axi_addr, len,
    output done, error, busy
  );
endinterface

// File: rtl/acpram_axi_cmd_queue.sv
// rtl/acpram_axi_cmd_queue.sv - two-port round-robin command queue issuing one transfer at a time
`timescale 1ns/1ps
module acpram_axi_cmd_queue #(
  parameter int ACPRAM_ADDR_WIDTH = 12,
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int TAG_WIDTH         = 4,
  parameter int DEPTH             = 4,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic                         req0_write,
  input  logic [ACPRAM_ADDR_WIDTH-1:0] req0_acpram_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]    req0_axi_addr,
  input  logic                         req0_len,
  input  logic [TAG_WIDTH-1:0]         req0_tag,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic                         req1_write,
  input  logic [ACPRAM_ADDR_WIDTH-1:0] req1_acpram_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]    req1_axi_addr,
  input  logic                         req1_len,
  input  logic [TAG_WIDTH-1:0]         req1_tag,
  output logic                         cpl0_valid,
  output logic                         cpl0_error,
  output logic [TAG_WIDTH-1:0]         cpl0_tag,
  output logic                         cpl1_valid,
  output logic                         cpl1_error,
  output logic [TAG_WIDTH-1:0]         cpl1_tag,
  acpram_axi_interface.master          acp,
  output logic [$clog2(DEPTH):0]       fifo_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PW:0]   FULL_LVL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic                         port;
    logic                         write;
    logic [ACPRAM_ADDR_WIDTH-1:0] acpram_addr;
    logic [AXI_ADDR_WIDTH-1:0]    axi_addr;
    logic                         len;
    logic [TAG_WIDTH-1:0]         tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CPL} state_t;

  state_t      state, state_nxt;
  cmd_t        mem [DEPTH];
  cmd_t        in_cmd, cur;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic        rr_last;
  logic        full, empty, grant0, grant1, push, pop;
  logic        err_q, timeout_hit;
  logic [TW-1:0] timer;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign fifo_level = count;

  // On contention the port that did not win the last accept is granted.
  assign grant0 = req0_valid & (~req1_valid | rr_last);
  assign grant1 = req1_valid & (~req0_valid | ~rr_last);
  assign req0_ready = grant0 & ~full;
  assign req1_ready = grant1 & ~full;
  assign push = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign pop  = (state == IDLE) & ~empty & ~acp.busy;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == T_LAST);

  always_comb begin
    in_cmd = '0;
    if (grant1) begin
      in_cmd = '{port: 1'b1, write: req1_write, acpram_addr: req1_acpram_addr,
                 axi_addr: req1_axi_addr, len: req1_len, tag: req1_tag};
    end else begin
      in_cmd = '{port: 1'b0, write: req0_write, acpram_addr: req0_acpram_addr,
                 axi_addr: req0_axi_addr, len: req0_len, tag: req0_tag};
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rr_last <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        rr_last <= grant1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Issue register holds the active command from pop until completion.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cur   <= '0;
      err_q <= 1'b0;
      timer <= '0;
    end else begin
      if (pop) cur <= mem[rd_ptr];
      if (state == ISSUE) timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;
      if (state == WAIT) begin
        if (acp.done) err_q <= acp.error;
        else if (timeout_hit) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (acp.done || timeout_hit) state_nxt = CPL;
      CPL:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acp.read        = (state == ISSUE) & ~cur.write;
    acp.write       = (state == ISSUE) &  cur.write;
    acp.acpram_addr = cur.acpram_addr;
    acp.axi_addr    = cur.axi_addr;
    acp.len         = cur.len;
    cpl0_valid      = (state == CPL) & ~cur.port;
    cpl1_valid      = (state == CPL) &  cur.port;
    cpl0_error      = cpl0_valid & err_q;
    cpl1_error      = cpl1_valid & err_q;
    cpl0_tag        = cpl0_valid ? cur.tag : '0;
    cpl1_tag        = cpl1_valid ? cur.tag : '0;
  end
endmodule
